// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request/priority stage.
// Command-register bit positions document where the decoded command bits come from.
package dma_pkg;

  localparam int DMA_NUM_CHANNELS = 4;

  localparam int CMD_DISABLE    = 2;
  localparam int CMD_ROTATE     = 4;
  localparam int CMD_DREQ_SENSE = 6;
  localparam int CMD_DACK_SENSE = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    SERVICE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Bundle of request, command, hold-handshake and grant signals around the arbiter.
// The master side drives requests and HLDA; the slave side is the arbiter itself.
interface dma_priority_arbiter_if #(
  parameter int NUM_CHANNELS = dma_pkg::DMA_NUM_CHANNELS,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
);

  logic [NUM_CHANNELS-1:0] DREQ;
  logic                    HLDA;
  logic [NUM_CHANNELS-1:0] maskReg;
  logic [NUM_CHANNELS-1:0] requestReg;
  logic                    rotatingPriority;
  logic                    controllerDisable;
  logic                    dreqSenseLow;
  logic                    dackSenseHigh;
  logic                    transferDone;

  logic                    HRQ;
  logic [NUM_CHANNELS-1:0] DACK;
  logic [CH_W-1:0]         activeChannel;
  logic                    serviceStart;
  dma_pkg::arb_state_e     state;

  // Hold handshake: HRQ stays high until HLDA answers or the request vanishes;
  // DACK and HRQ stay high for the whole service until transferDone or HLDA drops.
  modport master (
    output DREQ, HLDA, maskReg, requestReg, rotatingPriority,
           controllerDisable, dreqSenseLow, dackSenseHigh, transferDone,
    input  HRQ, DACK, activeChannel, serviceStart, state
  );

  modport slave (
    input  DREQ, HLDA, maskReg, requestReg, rotatingPriority,
           controllerDisable, dreqSenseLow, dackSenseHigh, transferDone,
    output HRQ, DACK, activeChannel, serviceStart, state
  );

endinterface

// File: rtl/dma_rotating_arbiter.sv
// Combinational priority picker: scans the effective requests starting at the
// channel named by ptr and wrapping around; ptr=0 gives plain fixed priority.
module dma_rotating_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eff,
  input  logic [CH_W-1:0]         ptr,
  output logic [CH_W-1:0]         winner,
  output logic                    any_req
);

  always_comb begin
    logic            found;
    logic [CH_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CHANNELS);
      if (!found && eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |eff;

endmodule

// File: rtl/dma_priority_arbiter.sv
// Request/priority stage of an 8237-style DMA controller: qualifies requests,
// arbitrates, runs the HRQ/HLDA handshake and hands a grant to timing-and-control.
module dma_priority_arbiter import dma_pkg::*; #(
  parameter int NUM_CHANNELS = DMA_NUM_CHANNELS,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input logic                   CLK,
  input logic                   RESET,
  dma_priority_arbiter_if.slave bus
);

  logic [NUM_CHANNELS-1:0] dreq_q;
  logic [NUM_CHANNELS-1:0] eff;
  logic [NUM_CHANNELS-1:0] dack_q, dack_d;
  logic [CH_W-1:0]         active_q, active_d;
  logic [CH_W-1:0]         ptr_q, ptr_d;
  logic [CH_W-1:0]         arb_ptr;
  logic [CH_W-1:0]         winner;
  logic                    any_req;
  logic                    hrq_q, hrq_d;
  logic                    start_q, start_d;
  arb_state_e              state_q, state_d;

  always_ff @(posedge CLK) begin
    if (RESET) dreq_q <= '0;
    else       dreq_q <= bus.DREQ;
  end

  // Software requests bypass the DREQ polarity; the mask overrides both.
  assign eff = ((dreq_q ^ {NUM_CHANNELS{bus.dreqSenseLow}}) | bus.requestReg)
               & ~bus.maskReg;

  // Fixed mode keeps the pointer value but arbitrates as if it were zero.
  assign arb_ptr = bus.rotatingPriority ? ptr_q : '0;

  dma_rotating_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_W        (CH_W)
  ) u_arb (
    .eff    (eff),
    .ptr    (arb_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      hrq_q    <= 1'b0;
      dack_q   <= '0;
      active_q <= '0;
      start_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      hrq_q    <= hrq_d;
      dack_q   <= dack_d;
      active_q <= active_d;
      start_q  <= start_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    dack_d   = dack_q;
    active_d = active_q;
    start_d  = 1'b0;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.controllerDisable && any_req) begin
          active_d = winner;
          hrq_d    = 1'b1;
          state_d  = HOLD_REQ;
        end
      end
      HOLD_REQ: begin
        // A withdrawn request beats a simultaneous HLDA.
        if (!any_req) begin
          hrq_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.HLDA) begin
          dack_d           = '0;
          dack_d[active_q] = 1'b1;
          start_d          = 1'b1;
          state_d          = SERVICE;
        end else begin
          active_d = winner;
        end
      end
      SERVICE: begin
        if (bus.transferDone) begin
          dack_d  = '0;
          hrq_d   = 1'b0;
          state_d = IDLE;
          if (bus.rotatingPriority) begin
            ptr_d = (active_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : active_q + 1'b1;
          end
        end else if (!bus.HLDA) begin
          dack_d  = '0;
          hrq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        dack_d  = '0;
        hrq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.HRQ           = hrq_q;
  assign bus.DACK          = bus.dackSenseHigh ? dack_q : ~dack_q;
  assign bus.activeChannel = active_q;
  assign bus.serviceStart  = start_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: priority modes, masking, polarity,
// withdrawal, CPU revoke and reset during service.
module tb_dma_priority_arbiter;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dma_priority_arbiter_if #(.NUM_CHANNELS(4)) bus ();

  dma_priority_arbiter #(.NUM_CHANNELS(4)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.DREQ              = 4'b0000;
    bus.HLDA              = 1'b0;
    bus.maskReg           = 4'b0000;
    bus.requestReg        = 4'b0000;
    bus.rotatingPriority  = 1'b0;
    bus.controllerDisable = 1'b0;
    bus.dreqSenseLow      = 1'b0;
    bus.dackSenseHigh     = 1'b1;
    bus.transferDone      = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.DREQ = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL reset_hrq got %b want 0", bus.HRQ); end
    checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("FAIL reset_dack_high got %b want 0000", bus.DACK); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", bus.state, IDLE); end
    checks++; if (bus.activeChannel !== 2'd0) begin errors++; $display("FAIL reset_active got %0d want 0", bus.activeChannel); end
    checks++; if (bus.serviceStart !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.serviceStart); end
    bus.dackSenseHigh = 1'b0;
    #1;
    checks++; if (bus.DACK !== 4'b1111) begin errors++; $display("FAIL reset_dack_low got %b want 1111", bus.DACK); end
    bus.dackSenseHigh = 1'b1;
    rst = 1'b0;
    bus.DREQ = 4'b0000;
    tick();
  endtask

  task automatic test_fixed();
    idle_inputs();
    apply_reset();
    bus.DREQ = 4'b0110;
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL fixed_hrq_latency got %b want 0", bus.HRQ); end
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin errors++; $display("FAIL fixed_hrq got %b want 1", bus.HRQ); end
    checks++; if (bus.activeChannel !== 2'd1) begin errors++; $display("FAIL fixed_active got %0d want 1", bus.activeChannel); end
    checks++; if (bus.state !== HOLD_REQ) begin errors++; $display("FAIL fixed_state_hold got %0d want %0d", bus.state, HOLD_REQ); end
    tick();
    tick();
    checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("FAIL fixed_dack_wait got %b want 0000", bus.DACK); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.serviceStart !== 1'b1) begin errors++; $display("FAIL fixed_start_pulse got %b want 1", bus.serviceStart); end
    checks++; if (bus.DACK !== 4'b0010) begin errors++; $display("FAIL fixed_dack got %b want 0010", bus.DACK); end
    checks++; if (bus.state !== SERVICE) begin errors++; $display("FAIL fixed_state_service got %0d want %0d", bus.state, SERVICE); end
    tick();
    checks++; if (bus.serviceStart !== 1'b0) begin errors++; $display("FAIL fixed_start_one_cycle got %b want 0", bus.serviceStart); end
    checks++; if (bus.DACK !== 4'b0010) begin errors++; $display("FAIL fixed_dack_hold got %b want 0010", bus.DACK); end
    bus.transferDone = 1'b1;
    bus.DREQ = 4'b0100;
    tick();
    bus.transferDone = 1'b0;
    bus.HLDA = 1'b0;
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL fixed_done_hrq got %b want 0", bus.HRQ); end
    checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("FAIL fixed_done_dack got %b want 0000", bus.DACK); end
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin errors++; $display("FAIL fixed_next_hrq got %b want 1", bus.HRQ); end
    checks++; if (bus.activeChannel !== 2'd2) begin errors++; $display("FAIL fixed_next_active got %0d want 2", bus.activeChannel); end
  endtask

  task automatic test_rotating();
    idle_inputs();
    apply_reset();
    bus.rotatingPriority = 1'b1;
    bus.DREQ = 4'b0010;
    tick();
    tick();
    checks++; if (bus.activeChannel !== 2'd1) begin errors++; $display("FAIL rot_first got %0d want 1", bus.activeChannel); end
    bus.HLDA = 1'b1;
    tick();
    bus.transferDone = 1'b1;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1111;
    tick();
    bus.transferDone = 1'b0;
    tick();
    checks++; if (bus.activeChannel !== 2'd2) begin errors++; $display("FAIL rot_second got %0d want 2", bus.activeChannel); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.DACK !== 4'b0100) begin errors++; $display("FAIL rot_second_dack got %b want 0100", bus.DACK); end
    bus.transferDone = 1'b1;
    bus.HLDA = 1'b0;
    tick();
    bus.transferDone = 1'b0;
    tick();
    checks++; if (bus.activeChannel !== 2'd3) begin errors++; $display("FAIL rot_third got %0d want 3", bus.activeChannel); end
    bus.HLDA = 1'b1;
    tick();
    bus.transferDone = 1'b1;
    bus.HLDA = 1'b0;
    tick();
    bus.transferDone = 1'b0;
    tick();
    checks++; if (bus.activeChannel !== 2'd0) begin errors++; $display("FAIL rot_wrap got %0d want 0", bus.activeChannel); end
  endtask

  task automatic test_mask_swreq();
    idle_inputs();
    apply_reset();
    bus.maskReg = 4'b0001;
    bus.DREQ = 4'b0001;
    tick();
    tick();
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL mask_hrq got %b want 0", bus.HRQ); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL mask_state got %0d want %0d", bus.state, IDLE); end
    bus.requestReg = 4'b1000;
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin errors++; $display("FAIL swreq_hrq got %b want 1", bus.HRQ); end
    checks++; if (bus.activeChannel !== 2'd3) begin errors++; $display("FAIL swreq_active got %0d want 3", bus.activeChannel); end
  endtask

  task automatic test_polarity_and_reset_mid_service();
    idle_inputs();
    bus.dreqSenseLow = 1'b1;
    bus.dackSenseHigh = 1'b0;
    bus.controllerDisable = 1'b1;
    bus.DREQ = 4'b1011;
    apply_reset();
    tick();
    checks++; if (bus.DACK !== 4'b1111) begin errors++; $display("FAIL pol_idle_dack got %b want 1111", bus.DACK); end
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL pol_disabled_hrq got %b want 0", bus.HRQ); end
    bus.controllerDisable = 1'b0;
    tick();
    checks++; if (bus.activeChannel !== 2'd2) begin errors++; $display("FAIL pol_active got %0d want 2", bus.activeChannel); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.DACK !== 4'b1011) begin errors++; $display("FAIL pol_service_dack got %b want 1011", bus.DACK); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL rstmid_hrq got %b want 0", bus.HRQ); end
    checks++; if (bus.DACK !== 4'b1111) begin errors++; $display("FAIL rstmid_dack got %b want 1111", bus.DACK); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", bus.state, IDLE); end
    checks++; if (bus.activeChannel !== 2'd0) begin errors++; $display("FAIL rstmid_active got %0d want 0", bus.activeChannel); end
  endtask

  task automatic test_withdraw();
    idle_inputs();
    apply_reset();
    bus.DREQ = 4'b0001;
    tick();
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin errors++; $display("FAIL wd_hrq_up got %b want 1", bus.HRQ); end
    bus.DREQ = 4'b0000;
    tick();
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL wd_hrq_down got %b want 0", bus.HRQ); end
    checks++; if (bus.serviceStart !== 1'b0) begin errors++; $display("FAIL wd_start got %b want 0", bus.serviceStart); end
    checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("FAIL wd_dack got %b want 0000", bus.DACK); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL wd_state got %0d want %0d", bus.state, IDLE); end
    bus.HLDA = 1'b0;
  endtask

  task automatic test_revoke();
    idle_inputs();
    apply_reset();
    bus.rotatingPriority = 1'b1;
    bus.DREQ = 4'b0010;
    tick();
    tick();
    bus.HLDA = 1'b1;
    tick();
    bus.controllerDisable = 1'b1;
    bus.maskReg = 4'b1111;
    tick();
    checks++; if (bus.state !== SERVICE) begin errors++; $display("FAIL rv_disable_holds got %0d want %0d", bus.state, SERVICE); end
    checks++; if (bus.DACK !== 4'b0010) begin errors++; $display("FAIL rv_dack_hold got %b want 0010", bus.DACK); end
    bus.controllerDisable = 1'b0;
    bus.maskReg = 4'b0000;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b0101;
    tick();
    checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("FAIL rv_dack_off got %b want 0000", bus.DACK); end
    checks++; if (bus.HRQ !== 1'b0) begin errors++; $display("FAIL rv_hrq_off got %b want 0", bus.HRQ); end
    tick();
    checks++; if (bus.activeChannel !== 2'd0) begin errors++; $display("FAIL rv_no_rotate got %0d want 0", bus.activeChannel); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_swreq();
    test_polarity_and_reset_mid_service();
    test_withdraw();
    test_revoke();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Request/priority stage of the 8237-style DMA controller; sits directly upstream of timing-and-control.
- Samples channel DREQs and software requests and applies mask and command-register polarity.
- Arbitrates with fixed or rotating priority and runs the HRQ/HLDA hold handshake with the CPU.
- Once a winner is granted, asserts its DACK and pulses serviceStart so timing-and-control leaves state SO.

Parameters:
- NUM_CHANNELS, 4, number of DMA channels.
- CH_W, $clog2(NUM_CHANNELS), width of channel index.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- DREQ  in  NUM_CHANNELS  hardware data requests, polarity set by dreqSenseLow
- HLDA  in  1  hold acknowledge from CPU
- maskReg  in  NUM_CHANNELS  1 = channel masked
- requestReg  in  NUM_CHANNELS  software request bits, always active-high
- rotatingPriority  in  1  command bit 4: 0 = fixed, 1 = rotating
- controllerDisable  in  1  command bit 2: blocks new arbitration
- dreqSenseLow  in  1  command bit 6: 1 = DREQ active-low
- dackSenseHigh  in  1  command bit 7: 1 = DACK active-high
- transferDone  in  1  one-cycle pulse from timing-and-control at end of service (TC, EOP or single-transfer end)
- HRQ  out  1  hold request to CPU
- DACK  out  NUM_CHANNELS  data acknowledge, polarity per dackSenseHigh
- activeChannel  out  CH_W  channel currently requested or serviced
- serviceStart  out  1  one-cycle pulse: grant issued to timing-and-control

Behaviour:
- Reset (synchronous, RESET high at posedge):
  - state=IDLE, HRQ=0, serviceStart=0, activeChannel=0.
  - Internal dackQ=0, so DACK is inactive: 4'b0000 if dackSenseHigh=1, 4'b1111 if 0.
  - Priority pointer reset so channel 0 is highest; dreqQ cleared.
  - RESET has priority over all other inputs and aborts any state immediately.
- DREQ is registered once (dreqQ) before use.
- Effective request per channel: eff[i] = ((dreqQ[i] ^ dreqSenseLow) | requestReg[i]) & ~maskReg[i].
- Priority:
  - Fixed mode: channel 0 highest, then ascending index.
  - Rotating mode: after a completed service of channel c, channel (c+1) mod NUM_CHANNELS becomes highest and c becomes lowest.
  - The pointer updates only on transferDone, never on abort.
  - Switching modes does not reset the pointer; fixed mode simply ignores it.
- DACK output = dackSenseHigh ? dackQ : ~dackQ. This output is combinational on the polarity input only.
- FSM states: IDLE, HOLD_REQ, SERVICE.
- IDLE:
  - If controllerDisable=0 and |eff: latch winner into activeChannel, set HRQ=1, go to HOLD_REQ.
  - Otherwise stay in IDLE.
- HOLD_REQ:
  - HRQ held high; winner re-evaluated every cycle and activeChannel updated.
  - If eff becomes 0 (request withdrawn or masked) before HLDA: HRQ=0, go to IDLE.
  - On HLDA=1: activeChannel frozen, dackQ = onehot(activeChannel), serviceStart=1 for exactly one cycle, go to SERVICE.
  - If withdrawal and HLDA occur in the same cycle, withdrawal wins: go to IDLE with no DACK.
- SERVICE:
  - HRQ and DACK held; new requests and mask changes are ignored.
  - controllerDisable does not abort a service in progress.
  - On transferDone: dackQ=0, HRQ=0, rotate pointer if rotatingPriority=1, go to IDLE.
  - On HLDA=0 without transferDone (CPU revoke): dackQ=0, HRQ=0, no rotation, go to IDLE.
  - If transferDone and HLDA=0 arrive together, treat as done (rotation applies).
- Latency:
  - DREQ asserted before edge k → dreqQ=1 after k → HRQ=1 after edge k+1.
  - HLDA high at edge m → DACK active and serviceStart=1 after edge m.
  - After a service ends, at least one IDLE cycle passes before HRQ can reassert.
- All outputs are registered except for the DACK polarity inversion.

Decomposition:
- Package dma_pkg holds:
  - NUM_CHANNELS default.
  - Arbiter state enum {IDLE, HOLD_REQ, SERVICE}.
  - Command-register bit-position constants (CMD_DISABLE=2, CMD_ROTATE=4, CMD_DREQ_SENSE=6, CMD_DACK_SENSE=7).
- One sub-module, dma_rotating_arbiter: purely combinational.
  - Inputs: eff vector and priority pointer.
  - Outputs: winner index and anyReq.
  - The FSM and registers stay in the top module.

Test Plan:
- Fixed priority: DREQ=4'b0110, HLDA high 2 cycles after HRQ → activeChannel=1, DACK=4'b0010 (dackSenseHigh=1), serviceStart for exactly one cycle; transferDone → HRQ=0, next grant goes to channel 2.
- Rotating priority: service channel 1, then DREQ=4'b1111 → next winner is channel 2; after channel 2 completes, winner is channel 3, then 0.
- Mask and software request: maskReg=4'b0001, DREQ=4'b0001 → HRQ stays 0; requestReg=4'b1000 → HRQ=1, winner channel 3.
- Polarity: dreqSenseLow=1, dackSenseHigh=0, DREQ=4'b1011 → channel 2 requests, DACK=4'b1011 during service, 4'b1111 at idle and reset.
- Withdrawal and revoke:
  - DREQ drops in HOLD_REQ before HLDA → HRQ=0, no serviceStart.
  - HLDA drops mid-SERVICE → DACK inactive next cycle, rotation pointer unchanged.
- Reset mid-SERVICE: RESET=1 while DACK active → next cycle HRQ=0, DACK inactive, state IDLE, channel 0 highest priority.
